nukv_privacy_path_scheduler: RTL and testbench

//  Per-request scheduler in front of the privacy datapath. Consumes one predicate word per request,

---
 rtl/nukv_privacy_pkg.sv | 14 +
 rtl/nukv_privacy_tag_fifo.sv | 48 ++++
 rtl/nukv_privacy_path_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_nukv_privacy_path_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nukv_privacy_pkg.sv
// Shared constants and FSM encoding for the privacy path scheduler.
package nukv_privacy_pkg;

    localparam logic [7:0] OPC_MATRIX  = 8'hFE;
    localparam logic       PATH_BYPASS = 1'b0;
    localparam logic       PATH_ROTATE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUTE  = 2'd1,
        ST_MATRIX = 2'd2
    } sched_state_t;

endpackage

// File: rtl/nukv_privacy_tag_fifo.sv
// First-word-fall-through 1-bit tag FIFO recording which path each routed request used.
module nukv_privacy_tag_fifo #(
    parameter int ADDR_BITS = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic pop_data,
    output logic full,
    output logic empty
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic                 mem_q [DEPTH];
    logic [ADDR_BITS:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS:0]   rd_ptr_q, rd_ptr_d;

    // Extra pointer bit distinguishes full from empty when the low bits match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[ADDR_BITS] != rd_ptr_q[ADDR_BITS]) &&
                      (wr_ptr_q[ADDR_BITS-1:0] == rd_ptr_q[ADDR_BITS-1:0]);
    assign pop_data = mem_q[rd_ptr_q[ADDR_BITS-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full)  wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop && !empty)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_ptr_q[ADDR_BITS-1:0]] <= push_data;
    end

endmodule

// File: rtl/nukv_privacy_path_scheduler.sv
// Steers each request's value words to bypass/rotation/matrix paths and merges results in order.
// Optional per-class statistics counters: define NUKV_PRIV_SCHED_STATS_EN.
module nukv_privacy_path_scheduler
    import nukv_privacy_pkg::*;
#(
    parameter int MEMORY_WIDTH        = 512,
    parameter int VALUE_SIZE_BYTES_NO = 2,
    parameter int TAG_ADDR_BITS       = 5,
    parameter int MAX_OUTSTANDING     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MEMORY_WIDTH-1:0] pred_data,
    input  logic                    pred_valid,
    output logic                    pred_ready,
    input  logic [MEMORY_WIDTH-1:0] value_data,
    input  logic                    value_valid,
    input  logic                    value_last,
    output logic                    value_ready,
    output logic [MEMORY_WIDTH-1:0] byp_in_data,
    output logic                    byp_in_valid,
    output logic                    byp_in_last,
    input  logic                    byp_in_ready,
    output logic [MEMORY_WIDTH-1:0] rot_in_data,
    output logic                    rot_in_valid,
    output logic                    rot_in_last,
    input  logic                    rot_in_ready,
    output logic [MEMORY_WIDTH-1:0] mtx_data,
    output logic                    mtx_valid,
    output logic                    mtx_last,
    input  logic                    mtx_ready,
    input  logic [MEMORY_WIDTH-1:0] byp_out_data,
    input  logic                    byp_out_valid,
    input  logic                    byp_out_last,
    output logic                    byp_out_ready,
    input  logic [MEMORY_WIDTH-1:0] rot_out_data,
    input  logic                    rot_out_valid,
    input  logic                    rot_out_last,
    output logic                    rot_out_ready,
    output logic [MEMORY_WIDTH-1:0] output_data,
    output logic                    output_valid,
    output logic                    output_last,
    input  logic                    output_ready,
`ifdef NUKV_PRIV_SCHED_STATS_EN
    output logic [31:0]             stat_byp_cnt,
    output logic [31:0]             stat_rot_cnt,
    output logic [31:0]             stat_mtx_cnt,
`endif
    output logic                    busy
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);

    sched_state_t     state_q, state_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] rot_pending_q, rot_pending_d;

    logic [7:0] opcode;
    logic       is_mtx, pred_ok, pred_acc, routed_acc, value_done;
    logic       tag_head, tag_full, tag_empty, tag_pop;
    logic       unused_pred_bits;

    assign opcode           = pred_data[8*VALUE_SIZE_BYTES_NO +: 8];
    assign unused_pred_bits = &{1'b0, pred_data};
    assign is_mtx           = (opcode == OPC_MATRIX);
    // Matrix reloads wait until no rotation is still in flight.
    assign pred_ok    = is_mtx ? (rot_pending_q == '0)
                               : (!tag_full && (outstanding_q < MAX_OUT_C));
    assign pred_ready = (state_q == ST_IDLE) && pred_valid && pred_ok;
    assign pred_acc   = pred_valid && pred_ready;
    assign routed_acc = pred_acc && !is_mtx;
    assign value_done = value_valid && value_ready && value_last;
    assign busy       = (state_q != ST_IDLE) || (outstanding_q != '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= PATH_BYPASS;
            outstanding_q <= '0;
            rot_pending_q <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            outstanding_q <= outstanding_d;
            rot_pending_q <= rot_pending_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (pred_acc) begin
                    sel_d   = opcode[0];
                    state_d = is_mtx ? ST_MATRIX : ST_ROUTE;
                end
            end
            ST_ROUTE, ST_MATRIX: begin
                if (value_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Input-side outputs
    always_comb begin
        value_ready  = 1'b0;
        byp_in_valid = 1'b0;
        rot_in_valid = 1'b0;
        mtx_valid    = 1'b0;
        case (state_q)
            ST_ROUTE: begin
                if (sel_q == PATH_ROTATE) begin
                    rot_in_valid = value_valid;
                    value_ready  = rot_in_ready;
                end else begin
                    byp_in_valid = value_valid;
                    value_ready  = byp_in_ready;
                end
            end
            ST_MATRIX: begin
                mtx_valid   = value_valid;
                value_ready = mtx_ready;
            end
            default: ;
        endcase
    end

    assign byp_in_data = value_data;
    assign rot_in_data = value_data;
    assign mtx_data    = value_data;
    assign byp_in_last = byp_in_valid && value_last;
    assign rot_in_last = rot_in_valid && value_last;
    assign mtx_last    = mtx_valid && value_last;

    // Output merge follows the head tag so results leave in request order.
    assign output_data   = tag_head ? rot_out_data : byp_out_data;
    assign output_valid  = !tag_empty && (tag_head ? rot_out_valid : byp_out_valid);
    assign output_last   = output_valid && (tag_head ? rot_out_last : byp_out_last);
    assign byp_out_ready = !tag_empty && (tag_head == PATH_BYPASS) && output_ready;
    assign rot_out_ready = !tag_empty && (tag_head == PATH_ROTATE) && output_ready;
    assign tag_pop       = output_valid && output_ready && output_last;

    always_comb begin
        outstanding_d = outstanding_q;
        rot_pending_d = rot_pending_q;
        if (routed_acc && !tag_pop)      outstanding_d = outstanding_q + 1'b1;
        else if (!routed_acc && tag_pop) outstanding_d = outstanding_q - 1'b1;
        if (routed_acc && opcode[0])     rot_pending_d = rot_pending_d + 1'b1;
        if (tag_pop && tag_head)         rot_pending_d = rot_pending_d - 1'b1;
    end

    nukv_privacy_tag_fifo #(
        .ADDR_BITS (TAG_ADDR_BITS)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (routed_acc),
        .push_data (opcode[0]),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

`ifdef NUKV_PRIV_SCHED_STATS_EN
    logic [31:0] stat_byp_q, stat_rot_q, stat_mtx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_byp_q <= '0;
            stat_rot_q <= '0;
            stat_mtx_q <= '0;
        end else if (pred_acc) begin
            if (is_mtx)         stat_mtx_q <= stat_mtx_q + 32'd1;
            else if (opcode[0]) stat_rot_q <= stat_rot_q + 32'd1;
            else                stat_byp_q <= stat_byp_q + 32'd1;
        end
    end

    assign stat_byp_cnt = stat_byp_q;
    assign stat_rot_cnt = stat_rot_q;
    assign stat_mtx_cnt = stat_mtx_q;
`endif

endmodule

// File: tb/tb_nukv_privacy_path_scheduler.sv
// Directed bench for nukv_privacy_path_scheduler; stat ports connected when NUKV_PRIV_SCHED_STATS_EN is set.
module tb_nukv_privacy_path_scheduler;

    localparam int MW = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [MW-1:0] pred_data = '0;
    logic          pred_valid = 1'b0;
    logic          pred_ready;
    logic [MW-1:0] value_data = '0;
    logic          value_valid = 1'b0;
    logic          value_last = 1'b0;
    logic          value_ready;
    logic [MW-1:0] byp_in_data, rot_in_data, mtx_data;
    logic          byp_in_valid, byp_in_last, rot_in_valid, rot_in_last, mtx_valid, mtx_last;
    logic          byp_in_ready = 1'b0;
    logic          rot_in_ready = 1'b0;
    logic          mtx_ready = 1'b0;
    logic [MW-1:0] byp_out_data = '0;
    logic          byp_out_valid = 1'b0;
    logic          byp_out_last = 1'b0;
    logic          byp_out_ready;
    logic [MW-1:0] rot_out_data = '0;
    logic          rot_out_valid = 1'b0;
    logic          rot_out_last = 1'b0;
    logic          rot_out_ready;
    logic [MW-1:0] output_data;
    logic          output_valid, output_last;
    logic          output_ready = 1'b0;
    logic          busy;
`ifdef NUKV_PRIV_SCHED_STATS_EN
    logic [31:0]   stat_byp_cnt, stat_rot_cnt, stat_mtx_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nukv_privacy_path_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .pred_data     (pred_data),
        .pred_valid    (pred_valid),
        .pred_ready    (pred_ready),
        .value_data    (value_data),
        .value_valid   (value_valid),
        .value_last    (value_last),
        .value_ready   (value_ready),
        .byp_in_data   (byp_in_data),
        .byp_in_valid  (byp_in_valid),
        .byp_in_last   (byp_in_last),
        .byp_in_ready  (byp_in_ready),
        .rot_in_data   (rot_in_data),
        .rot_in_valid  (rot_in_valid),
        .rot_in_last   (rot_in_last),
        .rot_in_ready  (rot_in_ready),
        .mtx_data      (mtx_data),
        .mtx_valid     (mtx_valid),
        .mtx_last      (mtx_last),
        .mtx_ready     (mtx_ready),
        .byp_out_data  (byp_out_data),
        .byp_out_valid (byp_out_valid),
        .byp_out_last  (byp_out_last),
        .byp_out_ready (byp_out_ready),
        .rot_out_data  (rot_out_data),
        .rot_out_valid (rot_out_valid),
        .rot_out_last  (rot_out_last),
        .rot_out_ready (rot_out_ready),
        .output_data   (output_data),
        .output_valid  (output_valid),
        .output_last   (output_last),
        .output_ready  (output_ready),
`ifdef NUKV_PRIV_SCHED_STATS_EN
        .stat_byp_cnt  (stat_byp_cnt),
        .stat_rot_cnt  (stat_rot_cnt),
        .stat_mtx_cnt  (stat_mtx_cnt),
`endif
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MW-1:0] mk_pred(input logic [7:0] op);
        logic [MW-1:0] p;
        p = '0;
        p[23:16] = op;
        p[7:0]   = 8'h5A;
        return p;
    endfunction

    // Present a pred, expect it accepted this cycle, advance one clock.
    task automatic accept_pred(input logic [7:0] op, input string tag);
        pred_data  = mk_pred(op);
        pred_valid = 1'b1;
        #1;
        chk(tag, pred_ready, 1'b1);
        tick();
        pred_valid = 1'b0;
        $display("pred op=%02h accepted (%s)", op, tag);
    endtask

    // Send one value beat into a routed path (rot selects which path is checked).
    task automatic send_word(input logic rot, input logic [MW-1:0] d, input logic last, input string tag);
        value_data  = d;
        value_valid = 1'b1;
        value_last  = last;
        #1;
        chk({tag, "_vrdy"}, value_ready, 1'b1);
        if (rot) begin
            chk({tag, "_rvld"}, rot_in_valid, 1'b1);
            chk({tag, "_rdat"}, rot_in_data, d);
            chk({tag, "_rlst"}, rot_in_last, last);
            chk({tag, "_bvld"}, byp_in_valid, 1'b0);
        end else begin
            chk({tag, "_bvld"}, byp_in_valid, 1'b1);
            chk({tag, "_bdat"}, byp_in_data, d);
            chk({tag, "_blst"}, byp_in_last, last);
            chk({tag, "_rvld"}, rot_in_valid, 1'b0);
        end
        tick();
        value_valid = 1'b0;
        value_last  = 1'b0;
        $display("value word %0h last=%0b (%s)", d[31:0], last, tag);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_pred_ready", pred_ready, 1'b0);
        chk("rst_value_ready", value_ready, 1'b0);
        chk("rst_out_valid", output_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_byp_out_ready", byp_out_ready, 1'b0);
`ifdef NUKV_PRIV_SCHED_STATS_EN
        chk("rst_stat_byp", stat_byp_cnt, 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        byp_in_ready = 1'b1;
        rot_in_ready = 1'b1;

        // Routed pass-through: bypass, 3 words
        accept_pred(8'h00, "pt_pred");
        chk("pt_busy", busy, 1'b1);
        send_word(1'b0, 512'hA1, 1'b0, "pt_w1");
        send_word(1'b0, 512'hA2, 1'b0, "pt_w2");
        send_word(1'b0, 512'hA3, 1'b1, "pt_w3");
        output_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            byp_out_valid = 1'b1;
            byp_out_data  = 512'hA0 + i;
            byp_out_last  = (i == 3);
            #1;
            chk("pt_out_valid", output_valid, 1'b1);
            chk("pt_out_data", output_data, 512'hA0 + i);
            chk("pt_out_last", output_last, (i == 3));
            chk("pt_byp_out_ready", byp_out_ready, 1'b1);
            tick();
            $display("output beat %0d of pass-through", i);
        end
        byp_out_valid = 1'b0;
        byp_out_last  = 1'b0;
        chk("pt_idle_busy", busy, 1'b0);

        // Ordering: rotation request first, bypass result arrives first
        accept_pred(8'h01, "ord_rot_pred");
        send_word(1'b1, 512'hB1, 1'b0, "ord_r1");
        send_word(1'b1, 512'hB2, 1'b1, "ord_r2");
        accept_pred(8'h00, "ord_byp_pred");
        send_word(1'b0, 512'hC1, 1'b1, "ord_b1");
        byp_out_valid = 1'b1; byp_out_data = 512'hCC; byp_out_last = 1'b1;
        #1;
        chk("ord_hold_valid", output_valid, 1'b0);
        chk("ord_hold_bready", byp_out_ready, 1'b0);
        rot_out_valid = 1'b1; rot_out_data = 512'hD1; rot_out_last = 1'b0;
        #1;
        chk("ord_rot0_data", output_data, 512'hD1);
        chk("ord_rot0_rready", rot_out_ready, 1'b1);
        chk("ord_rot0_bready", byp_out_ready, 1'b0);
        tick();
        rot_out_data = 512'hD2; rot_out_last = 1'b1;
        #1;
        chk("ord_rot1_last", output_last, 1'b1);
        tick();
        rot_out_valid = 1'b0; rot_out_last = 1'b0;
        #1;
        chk("ord_byp_valid", output_valid, 1'b1);
        chk("ord_byp_data", output_data, 512'hCC);
        tick();
        byp_out_valid = 1'b0; byp_out_last = 1'b0;
        chk("ord_done_busy", busy, 1'b0);
        $display("ordering sequence complete");

        // Matrix gating behind an outstanding rotation
        output_ready = 1'b0;
        accept_pred(8'h01, "mg_rot_pred");
        send_word(1'b1, 512'hE1, 1'b1, "mg_r1");
        pred_data = mk_pred(8'hFE); pred_valid = 1'b1;
        #1;
        chk("mg_blocked0", pred_ready, 1'b0);
        tick();
        tick();
        chk("mg_blocked1", pred_ready, 1'b0);
        output_ready = 1'b1; rot_out_valid = 1'b1; rot_out_last = 1'b1; rot_out_data = 512'hE9;
        #1;
        chk("mg_blocked_popcycle", pred_ready, 1'b0);
        tick();
        rot_out_valid = 1'b0; rot_out_last = 1'b0;
        #1;
        chk("mg_unblocked", pred_ready, 1'b1);
        tick();
        pred_valid = 1'b0;
        mtx_ready = 1'b1; value_valid = 1'b1; value_data = 512'hF1; value_last = 1'b1;
        #1;
        chk("mg_mtx_valid", mtx_valid, 1'b1);
        chk("mg_mtx_data", mtx_data, 512'hF1);
        chk("mg_mtx_last", mtx_last, 1'b1);
        chk("mg_value_ready", value_ready, 1'b1);
        chk("mg_byp_in_valid", byp_in_valid, 1'b0);
        chk("mg_rot_in_valid", rot_in_valid, 1'b0);
        tick();
        value_valid = 1'b0; value_last = 1'b0; mtx_ready = 1'b0;
        byp_out_valid = 1'b1; byp_out_last = 1'b1;
        #1;
        chk("mg_no_tag", output_valid, 1'b0);
        chk("mg_busy", busy, 1'b0);
        byp_out_valid = 1'b0; byp_out_last = 1'b0;
        $display("matrix gating sequence complete");

        // Credit limit: 16 bypass requests with output stalled
        output_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            accept_pred(8'h00, "cr_fill");
            send_word(1'b0, 512'h100 + i, 1'b1, "cr_w");
        end
        pred_data = mk_pred(8'h00); pred_valid = 1'b1;
        #1;
        chk("cr_17_blocked", pred_ready, 1'b0);
        tick();
        chk("cr_17_still_blocked", pred_ready, 1'b0);
        output_ready = 1'b1; byp_out_valid = 1'b1; byp_out_last = 1'b1; byp_out_data = 512'h77;
        #1;
        chk("cr_pop_valid", output_valid, 1'b1);
        tick();
        // Simultaneous: accept 17th while the next output pop happens
        chk("sim_accept", pred_ready, 1'b1);
        chk("sim_pop_valid", output_valid, 1'b1);
        tick();
        pred_valid = 1'b0; output_ready = 1'b0;
        send_word(1'b0, 512'h1FF, 1'b1, "sim_w");
        accept_pred(8'h01, "sim_rot_pred");
        send_word(1'b1, 512'h2FF, 1'b1, "sim_rw");
        pred_data = mk_pred(8'h00); pred_valid = 1'b1;
        #1;
        chk("sim_credit_full", pred_ready, 1'b0);
        pred_valid = 1'b0;
        output_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("sim_drain_byp", output_valid, 1'b1);
            tick();
        end
        #1;
        chk("sim_rot_head_wait", output_valid, 1'b0);
        byp_out_valid = 1'b0; byp_out_last = 1'b0;
        rot_out_valid = 1'b1; rot_out_last = 1'b1; rot_out_data = 512'h2FF;
        #1;
        chk("sim_rot_tail_data", output_data, 512'h2FF);
        tick();
        rot_out_valid = 1'b0; rot_out_last = 1'b0;
        chk("sim_drained_busy", busy, 1'b0);
        $display("credit and simultaneous sequence complete");

        // Reset during ROUTE beat 2
        accept_pred(8'h01, "rs_pred");
        send_word(1'b1, 512'h31, 1'b0, "rs_w1");
        value_valid = 1'b1; value_data = 512'h32;
        rot_out_valid = 1'b1;
        #1;
        chk("rs_pre_rvld", rot_in_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("rs_rot_in_valid", rot_in_valid, 1'b0);
        chk("rs_value_ready", value_ready, 1'b0);
        chk("rs_out_valid", output_valid, 1'b0);
        chk("rs_rot_out_ready", rot_out_ready, 1'b0);
        chk("rs_busy", busy, 1'b0);
`ifdef NUKV_PRIV_SCHED_STATS_EN
        chk("rs_stat_byp", stat_byp_cnt, 32'd0);
        chk("rs_stat_rot", stat_rot_cnt, 32'd0);
        chk("rs_stat_mtx", stat_mtx_cnt, 32'd0);
`endif
        value_valid = 1'b0; rot_out_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        accept_pred(8'h00, "rs_new_pred");
        send_word(1'b0, 512'h41, 1'b1, "rs_new_w");
        byp_out_valid = 1'b1; byp_out_last = 1'b1; byp_out_data = 512'h41;
        #1;
        chk("rs_new_out_data", output_data, 512'h41);
        chk("rs_new_out_valid", output_valid, 1'b1);
        tick();
        byp_out_valid = 1'b0; byp_out_last = 1'b0;
        chk("rs_final_busy", busy, 1'b0);
        $display("reset sequence complete");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
